// File: rtl/msg_sched_feeder.sv
// Batches up to four padded blocks, then drives W0..W15 of four interleaved lanes into expand over 256 RUN cycles.
// First RUN cycle follows the completing accept; blk_ready_o is low for the whole RUN phase.
module msg_sched_feeder (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic         blk_last_i,
  output logic         send_o,
  output logic [31:0]  data_o,
  output logic         tag_valid_o,
  output logic [1:0]   tag_lane_o,
  output logic [5:0]   tag_idx_o,
  output logic         tag_src_o,
  output logic [3:0]   lane_mask_o,
  output logic         batch_done_o
);

  typedef enum logic {FILL, RUN} state_e;

  state_e      state_q, state_d;
  logic [2:0]  nfill_q, nfill_d;
  logic [7:0]  c_q, c_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wbuf_q [4][16];
  logic [31:0] word_d;

  logic        send_q, send_d;
  logic [31:0] data_q, data_d;
  logic        tvld_q, tvld_d;
  logic [1:0]  tlane_q, tlane_d;
  logic [5:0]  tidx_q, tidx_d;
  logic        tsrc_q, tsrc_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    nfill_d = nfill_q;
    c_d     = c_q;
    mask_d  = mask_q;
    if (state_q == FILL) begin
      if (blk_valid_i) begin
        nfill_d                 = nfill_q + 3'd1;
        mask_d[nfill_q[1:0]]    = 1'b1;
        if (nfill_q == 3'd3 || blk_last_i) begin
          state_d = RUN;
          c_d     = 8'd0;
        end
      end
    end else if (c_q == 8'd255) begin
      state_d = FILL;
      nfill_d = 3'd0;
      mask_d  = 4'd0;
      c_d     = 8'd0;
    end else begin
      c_d = c_q + 8'd1;
    end

    // Entering RUN always starts at lane 0 W0, which may be the block being accepted this edge.
    if (state_q == FILL) begin
      word_d = (nfill_q == 3'd0) ? blk_data_i[511:480] : wbuf_q[0][0];
    end else begin
      word_d = wbuf_q[c_d[1:0]][c_d[5:2]];
    end

    send_d  = 1'b0;
    data_d  = 32'd0;
    tvld_d  = 1'b0;
    tlane_d = 2'd0;
    tidx_d  = 6'd0;
    tsrc_d  = 1'b0;
    done_d  = 1'b0;
    if (state_d == RUN) begin
      send_d  = (c_d[7:6] == 2'd0);
      data_d  = (send_d && mask_d[c_d[1:0]]) ? word_d : 32'd0;
      tvld_d  = mask_d[c_d[1:0]];
      tlane_d = c_d[1:0];
      tidx_d  = c_d[7:2];
      tsrc_d  = (c_d[7:6] != 2'd0);
      done_d  = (c_d == 8'd255);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      nfill_q <= 3'd0;
      c_q     <= 8'd0;
      mask_q  <= 4'd0;
      send_q  <= 1'b0;
      data_q  <= 32'd0;
      tvld_q  <= 1'b0;
      tlane_q <= 2'd0;
      tidx_q  <= 6'd0;
      tsrc_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nfill_q <= nfill_d;
      c_q     <= c_d;
      mask_q  <= mask_d;
      send_q  <= send_d;
      data_q  <= data_d;
      tvld_q  <= tvld_d;
      tlane_q <= tlane_d;
      tidx_q  <= tidx_d;
      tsrc_q  <= tsrc_d;
      done_q  <= done_d;
    end
  end

  // Word storage needs no reset: lanes are only read after being written, stale lanes are masked.
  always_ff @(posedge clk_i) begin
    if (blk_valid_i && state_q == FILL) begin
      for (int w = 0; w < 16; w++) begin
        wbuf_q[nfill_q[1:0]][w] <= blk_data_i[511-32*w -: 32];
      end
    end
  end

  assign blk_ready_o  = (state_q == FILL);
  assign send_o       = send_q;
  assign data_o       = data_q;
  assign tag_valid_o  = tvld_q;
  assign tag_lane_o   = tlane_q;
  assign tag_idx_o    = tidx_q;
  assign tag_src_o    = tsrc_q;
  assign lane_mask_o  = mask_q;
  assign batch_done_o = done_q;

endmodule

// File: tb/tb_msg_sched_feeder.sv
// Directed bench for msg_sched_feeder: abc block, full batch, stall, back-to-back and mid-RUN reset.
module tb_msg_sched_feeder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic [511:0] blk_data_i;
  logic         blk_last_i;
  logic         send_o;
  logic [31:0]  data_o;
  logic         tag_valid_o;
  logic [1:0]   tag_lane_o;
  logic [5:0]   tag_idx_o;
  logic         tag_src_o;
  logic [3:0]   lane_mask_o;
  logic         batch_done_o;

  always #5 clk_i = ~clk_i;

  msg_sched_feeder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i), .blk_last_i(blk_last_i),
    .send_o(send_o), .data_o(data_o),
    .tag_valid_o(tag_valid_o), .tag_lane_o(tag_lane_o), .tag_idx_o(tag_idx_o),
    .tag_src_o(tag_src_o), .lane_mask_o(lane_mask_o), .batch_done_o(batch_done_o)
  );

  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

  int           n_chk = 0;
  int           n_bad = 0;
  logic [511:0] exp_blk [4];
  logic [3:0]   exp_mask;
  int           abc_lane;
  logic [31:0]  cap [4][16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] mk(input int k);
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[511-32*w -: 32] = {8'(k), 8'(w), 16'hC3A5};
    return r;
  endfunction

  task automatic push(input logic [511:0] d, input logic last);
    @(negedge clk_i);
    check("ready_fill", blk_ready_o, 1);
    blk_valid_i = 1'b1;
    blk_data_i  = d;
    blk_last_i  = last;
    @(posedge clk_i);
    #1;
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
  endtask

  // Observes one full RUN phase starting with the next falling edge as c = 0.
  task automatic watch();
    int send_cnt;
    int done_cnt;
    int lane;
    int idx;
    logic [31:0] w;
    send_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk_i);
      lane = c % 4;
      idx  = c / 4;
      w    = exp_blk[lane][511-32*(idx%16) -: 32];
      check("ready_run", blk_ready_o, 0);
      check("send", send_o, c < 64);
      check("tag_lane", tag_lane_o, lane);
      check("tag_idx", tag_idx_o, idx);
      check("tag_src", tag_src_o, idx >= 16);
      check("tag_valid", tag_valid_o, exp_mask[lane]);
      check("lane_mask", lane_mask_o, exp_mask);
      check("data", data_o, (c < 64 && exp_mask[lane]) ? w : 32'd0);
      check("done", batch_done_o, c == 255);
      if (c < 64) cap[lane][idx%16] = data_o;
      if (abc_lane >= 0 && c == 64 + abc_lane)
        check("w16", sig1(cap[abc_lane][14]) + cap[abc_lane][9] + sig0(cap[abc_lane][1]) + cap[abc_lane][0],
              32'h61626380);
      if (abc_lane >= 0 && c == 68 + abc_lane)
        check("w17", sig1(cap[abc_lane][15]) + cap[abc_lane][10] + sig0(cap[abc_lane][2]) + cap[abc_lane][1],
              32'h000F0000);
      send_cnt += int'(send_o);
      done_cnt += int'(batch_done_o);
    end
    check("send_cnt", send_cnt, 64);
    check("done_cnt", done_cnt, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, blk_ready_o, 1);
    check({tag, "_send"}, send_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_tvalid"}, tag_valid_o, 0);
    check({tag, "_lane"}, tag_lane_o, 0);
    check({tag, "_idx"}, tag_idx_o, 0);
    check({tag, "_src"}, tag_src_o, 0);
    check({tag, "_mask"}, lane_mask_o, 0);
    check({tag, "_done"}, batch_done_o, 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    blk_valid_i = 1'b0;
    blk_data_i  = '0;
    blk_last_i  = 1'b0;
    for (int k = 0; k < 4; k++) exp_blk[k] = '0;
    repeat (3) @(negedge clk_i);
    check_idle("rst");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle("post_rst");

    // Single abc block, partial batch.
    exp_blk[0] = ABC;
    exp_mask   = 4'b0001;
    abc_lane   = 0;
    push(ABC, 1'b1);
    watch();
    @(negedge clk_i);
    check_idle("after_abc");

    // Four distinct blocks, lane 2 carries abc, last asserted with the 4th.
    for (int k = 0; k < 4; k++) exp_blk[k] = (k == 2) ? ABC : mk(k + 1);
    exp_mask = 4'b1111;
    abc_lane = 2;
    for (int k = 0; k < 4; k++) push(exp_blk[k], k == 3);
    watch();

    // Stall: valid toggles, last with valid low is ignored, 4th block 10 cycles late.
    for (int k = 0; k < 4; k++) exp_blk[k] = mk(k + 8);
    abc_lane = -1;
    for (int k = 0; k < 3; k++) begin
      push(exp_blk[k], 1'b0);
      @(negedge clk_i);
      blk_last_i = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      blk_last_i = 1'b1;
      check("stall_send", send_o, 0);
      check("stall_ready", blk_ready_o, 1);
      check("stall_mask", lane_mask_o, 4'b0111);
    end
    @(negedge clk_i);
    blk_valid_i = 1'b1;
    blk_data_i  = exp_blk[3];
    blk_last_i  = 1'b0;
    @(posedge clk_i);
    #1;
    // Keep valid high through RUN with the next batch's abc block waiting.
    blk_data_i = ABC;
    blk_last_i = 1'b1;
    watch();
    @(negedge clk_i);
    check_idle("b2b_fill");
    @(posedge clk_i);
    #1;
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
    exp_blk[0] = ABC;
    exp_mask   = 4'b0001;
    abc_lane   = 0;
    watch();

    // Reset at c = 100.
    push(ABC, 1'b1);
    repeat (101) @(negedge clk_i);
    check("c100_idx", tag_idx_o, 25);
    check("c100_tvalid", tag_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle("rst_release");
    push(ABC, 1'b1);
    watch();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/msg_sched_feeder.md
# msg_sched_feeder

Front-end writer for the `expand` message-schedule expander. It collects up to four 512-bit padded SHA-256 blocks into a batch and drives them into `expand` as four interleaved lanes. It supplies W0..W15 on `send_o`/`data_o` and generates a continuous tag stream that identifies the lane and word index for every W word. The tag stream covers both the words this block drives and the words `expand` returns, so the downstream compression stage can consume W0..W63 without its own counters.

## Interface
- No parameters. Lane count is fixed at 4 by the expander's 4-deep-per-slot pipeline.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low; also resets `expand`.
- `blk_valid_i` in 1: upstream block valid.
- `blk_ready_o` out 1: block accepted on a cycle with valid && ready.
- `blk_data_i` in 512: padded block, W0 in [511:480], W15 in [31:0].
- `blk_last_i` in 1: qualifies the accepted block as the last of a partial batch.
- `send_o` out 1: connects to `expand.send_i`.
- `data_o` out 32: connects to `expand.data_i`.
- `tag_valid_o` out 1: the W word in this cycle belongs to an active lane.
- `tag_lane_o` out 2: lane of the current W word.
- `tag_idx_o` out 6: index 0..63 of the current W word.
- `tag_src_o` out 1: 0 = word is on `data_o` (idx<16); 1 = word is on `expand.data_o`.
- `lane_mask_o` out 4: active lanes of the current batch.
- `batch_done_o` out 1: one-cycle pulse in the last RUN cycle.

## Operation
- Buffer: 4 × 16 × 32-bit word registers plus a 3-bit fill count `nfill` (0..4).
- State FILL (reset state):
  - `blk_ready_o` = 1.
  - On each accept, the block is stored in lane `nfill`, `nfill` increments, and `lane_mask` bit `nfill` is set.
  - Transition to RUN after an accept when `nfill` becomes 4, or when `blk_last_i` = 1 on the accepted block.
  - `blk_last_i` with the 4th block behaves the same as a full batch.
  - `blk_last_i` is ignored when `blk_valid_i` = 0.
- State RUN:
  - `blk_ready_o` = 0. An 8-bit counter `c` runs 0..255.
  - Word timing: lane = c[1:0], idx = c[7:2].
  - `send_o` = 1 for c < 64, else 0.
  - `data_o` = buf[lane][idx] for c < 64; inactive lanes drive 0. Otherwise `data_o` = 0.
  - Tags: `tag_lane_o` = lane, `tag_idx_o` = idx, `tag_src_o` = (idx ≥ 16), `tag_valid_o` = `lane_mask`[lane].
  - At c = 255: `batch_done_o` = 1. Next state is FILL with `nfill` = 0 and `lane_mask` = 0, and the buffer is left stale.
- Expander contract: if W0 of lane 0 is driven in cycle t0, `expand.data_o` carries Wk of lane l in cycle t0 + 4k + l for k = 16..63. Tags are therefore valid for both sources in the same cycle: c = 4k + l.
- Inactive lanes still pass through `expand`. Their words are don't-care, and `tag_valid_o` = 0 for them.

## Timing
- Every output is a function of registered state only; there is no combinational path from `blk_*` inputs to any output except none.
- Reset values: state FILL, `nfill` 0, `c` 0, `lane_mask_o` 0, `send_o` 0, `data_o` 0, all tags 0, `batch_done_o` 0, `blk_ready_o` 1 (derived from the FILL state).
- Start latency: the block that completes a batch is accepted at edge E. The first RUN cycle (c = 0, lane 0 W0 on `data_o`) is the cycle following E.
- Batch period: 256 RUN cycles plus the FILL cycles. Back-to-back: the first FILL cycle after `batch_done_o` already accepts.
- Reset mid-RUN: immediately returns to FILL with all state cleared. `expand` is cleared by the same reset; no partial words are tagged afterwards.

## Test plan
- Single "abc" block: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, `blk_last_i` = 1.
  - Required: `lane_mask_o` = 4'b0001.
  - Required: `tag_valid_o` only when c[1:0] = 0.
  - Required: with idx = 16, `tag_src_o` = 1 and `expand.data_o` = 0x61626380; with idx = 17, 0x000F0000.
- Four distinct blocks with lane 2 = "abc":
  - Required: the idx = 16, lane 2 tag coincides with `expand.data_o` = 0x61626380.
  - Required: `send_o` is high for exactly 64 cycles.
  - Required: `batch_done_o` pulses once, 255 cycles after c = 0.
- Upstream stall: `blk_valid_i` toggles, and the 4th block arrives 10 cycles late.
  - Required: no RUN until that accept.
  - Required: `blk_ready_o` = 0 throughout RUN, even with `blk_valid_i` held high.
- Back-to-back batches: a new block is presented at `batch_done_o`.
  - Required: it is accepted in the next cycle into lane 0.
  - Required: tags for the previous batch end exactly at c = 255.
- Reset asserted at c = 100:
  - Required: all outputs return to reset values asynchronously.
  - Required: the next batch runs correctly with the "abc" W16 value.
